// File: rtl/stream_demux4_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stream_demux4_if: handshake/bus bundle for the 1-to-4 demux (rev 1.0) |
// +--------------------------------------------------------------------+
interface stream_demux4_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [CNT_W-1:0] cnt_c;
  logic [CNT_W-1:0] cnt_d;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_a, out_b, out_c, out_d, out_valid,
    input  cnt_a, cnt_b, cnt_c, cnt_d
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_a, out_b, out_c, out_d, out_valid,
    output cnt_a, cnt_b, cnt_c, cnt_d
  );
endinterface
`default_nettype wire

// File: rtl/stream_demux4.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stream_demux4: registered 1-to-4 stream demux with per-port         |
// | single-entry holding registers and saturating counters (rev 1.0)    |
// +--------------------------------------------------------------------+
module stream_demux4 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  stream_demux4_if.slave  bus
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  slot_state_e      state_q [4];
  slot_state_e      state_d [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [WIDTH-1:0] data_d  [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];

  logic       w_in_ready;
  logic       w_in_fire;
  logic [3:0] w_out_fire;

  // Readiness looks only at the addressed slot, so a stall elsewhere is invisible here.
  assign w_in_ready = (state_q[bus.in_sel] == ST_EMPTY) || bus.out_ready[bus.in_sel];
  assign w_in_fire  = bus.in_valid && w_in_ready;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i]    = state_q[i];
      data_d[i]     = data_q[i];
      cnt_d[i]      = cnt_q[i];
      w_out_fire[i] = (state_q[i] == ST_FULL) && bus.out_ready[i];

      if (w_in_fire && (bus.in_sel == 2'(i))) begin
        state_d[i] = ST_FULL;
        data_d[i]  = bus.in_data;
      end else if (w_out_fire[i]) begin
        state_d[i] = ST_EMPTY;
      end

      if (w_out_fire[i] && (cnt_q[i] != C_CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= ST_EMPTY;
        data_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  generate
    for (genvar g = 0; g < 4; g++) begin : g_valid
      assign bus.out_valid[g] = (state_q[g] == ST_FULL);
    end
  endgenerate

  assign bus.in_ready = w_in_ready;
  assign bus.out_a    = data_q[0];
  assign bus.out_b    = data_q[1];
  assign bus.out_c    = data_q[2];
  assign bus.out_d    = data_q[3];
  assign bus.cnt_a    = cnt_q[0];
  assign bus.cnt_b    = cnt_q[1];
  assign bus.cnt_c    = cnt_q[2];
  assign bus.cnt_d    = cnt_q[3];

endmodule
`default_nettype wire

// File: tb/tb_stream_demux4.sv
`default_nettype none
// Bench for stream_demux4: two instances (8-bit and 2-bit counters) share one
// stimulus stream and are checked against a queue-based scoreboard every cycle.
module tb_stream_demux4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  stream_demux4_if #(.WIDTH(32), .CNT_W(8)) if8 ();
  stream_demux4_if #(.WIDTH(32), .CNT_W(2)) if2 ();

  stream_demux4 #(.WIDTH(32), .CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  stream_demux4 #(.WIDTH(32), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  assign if2.in_data   = if8.in_data;
  assign if2.in_sel    = if8.in_sel;
  assign if2.in_valid  = if8.in_valid;
  assign if2.out_ready = if8.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] o8 [4];
  logic [31:0] o2 [4];
  logic [7:0]  c8 [4];
  logic [1:0]  c2 [4];
  assign o8[0] = if8.out_a; assign o8[1] = if8.out_b; assign o8[2] = if8.out_c; assign o8[3] = if8.out_d;
  assign o2[0] = if2.out_a; assign o2[1] = if2.out_b; assign o2[2] = if2.out_c; assign o2[3] = if2.out_d;
  assign c8[0] = if8.cnt_a; assign c8[1] = if8.cnt_b; assign c8[2] = if8.cnt_c; assign c8[3] = if8.cnt_d;
  assign c2[0] = if2.cnt_a; assign c2[1] = if2.cnt_b; assign c2[2] = if2.cnt_c; assign c2[3] = if2.cnt_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each port is a queue of undelivered words plus a delivery tally.
  logic [31:0] pend [4][$];
  logic [31:0] last [4];
  int          total [4];

  function automatic int sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  function automatic logic model_ready(input logic [1:0] s, input logic [3:0] ordy);
    return (pend[s].size() == 0) || ordy[s];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        pend[i].delete();
        last[i]  = '0;
        total[i] = 0;
      end
    end else begin
      logic acc;
      acc = if8.in_valid && model_ready(if8.in_sel, if8.out_ready);
      for (int i = 0; i < 4; i++) begin
        if (pend[i].size() > 0 && if8.out_ready[i]) begin
          void'(pend[i].pop_front());
          total[i]++;
        end
      end
      if (acc) begin
        pend[if8.in_sel].push_back(if8.in_data);
        last[if8.in_sel] = if8.in_data;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("valid8[%0d]", i), 64'(if8.out_valid[i]), 64'(pend[i].size() > 0));
        chk($sformatf("valid2[%0d]", i), 64'(if2.out_valid[i]), 64'(pend[i].size() > 0));
        chk($sformatf("data8[%0d]", i), 64'(o8[i]), 64'(last[i]));
        chk($sformatf("data2[%0d]", i), 64'(o2[i]), 64'(last[i]));
        chk($sformatf("cnt8[%0d]", i), 64'(c8[i]), 64'(sat(total[i], 255)));
        chk($sformatf("cnt2[%0d]", i), 64'(c2[i]), 64'(sat(total[i], 3)));
      end
      chk("in_ready8", 64'(if8.in_ready), 64'(model_ready(if8.in_sel, if8.out_ready)));
      chk("in_ready2", 64'(if2.in_ready), 64'(model_ready(if8.in_sel, if8.out_ready)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [1:0] s, input logic v);
    if8.in_data  = d;
    if8.in_sel   = s;
    if8.in_valid = v;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(32'h0, 2'd0, 1'b0);
    if8.out_ready = 4'b1111;

    // Reset / idle
    repeat (3) cyc();
    chk("rst_valid", 64'(if8.out_valid), 64'h0);
    chk("rst_out_a", 64'(if8.out_a), 64'h0);
    chk("rst_cnt_d", 64'(if8.cnt_d), 64'h0);
    chk("rst_in_ready", 64'(if8.in_ready), 64'h1);
    rst_n = 1'b1;
    cyc();

    // Single routing to port c
    drive(32'h12153524, 2'd2, 1'b1);
    cyc();
    drive(32'h0, 2'd0, 1'b0);
    #1;
    chk("single_valid", 64'(if8.out_valid), 64'h4);
    chk("single_out_c", 64'(if8.out_c), 64'h12153524);
    cyc();
    chk("single_drained", 64'(if8.out_valid), 64'h0);
    chk("single_cnt_c", 64'(if8.cnt_c), 64'h1);

    // Back-to-back streaming on port a
    for (int k = 0; k < 8; k++) begin
      drive(32'(k), 2'd0, 1'b1);
      #1;
      chk("b2b_in_ready", 64'(if8.in_ready), 64'h1);
      cyc();
      chk("b2b_out_a", 64'(if8.out_a), 64'(k));
    end
    drive(32'h0, 2'd0, 1'b0);
    cyc();
    chk("b2b_cnt_a8", 64'(if8.cnt_a), 64'd8);
    chk("b2b_cnt_a2", 64'(if2.cnt_a), 64'd3);

    // Stall isolation on port b
    if8.out_ready = 4'b1101;
    drive(32'hAAAA0001, 2'd1, 1'b1);
    cyc();
    drive(32'hAAAA0002, 2'd1, 1'b1);
    #1;
    chk("stall_in_ready", 64'(if8.in_ready), 64'h0);
    cyc();
    chk("stall_hold_b", 64'(if8.out_b), 64'hAAAA0001);
    drive(32'hBBBB0003, 2'd3, 1'b1);
    #1;
    chk("stall_d_ready", 64'(if8.in_ready), 64'h1);
    cyc();
    chk("stall_out_d", 64'(if8.out_d), 64'hBBBB0003);
    chk("stall_still_b", 64'(if8.out_b), 64'hAAAA0001);
    if8.out_ready = 4'b1111;
    drive(32'hAAAA0002, 2'd1, 1'b1);
    cyc();
    chk("stall_order_b", 64'(if8.out_b), 64'hAAAA0002);
    chk("stall_cnt_b1", 64'(if8.cnt_b), 64'd1);
    drive(32'h0, 2'd0, 1'b0);
    cyc();
    chk("stall_cnt_b2", 64'(if8.cnt_b), 64'd2);

    // Simultaneous drain/refill on port a
    if8.out_ready = 4'b0000;
    drive(32'hC0DE0001, 2'd0, 1'b1);
    cyc();
    if8.out_ready = 4'b0001;
    drive(32'hC0DE0002, 2'd0, 1'b1);
    #1;
    chk("refill_ready", 64'(if8.in_ready), 64'h1);
    cyc();
    drive(32'h0, 2'd0, 1'b0);
    if8.out_ready = 4'b0000;
    #1;
    chk("refill_valid", 64'(if8.out_valid[0]), 64'h1);
    chk("refill_out_a", 64'(if8.out_a), 64'hC0DE0002);
    chk("refill_cnt_a", 64'(if8.cnt_a), 64'd9);

    // Saturation on port d (1 transfer already done there)
    if8.out_ready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      drive(32'hD0000000 + 32'(k), 2'd3, 1'b1);
      cyc();
    end
    drive(32'h0, 2'd0, 1'b0);
    cyc();
    chk("sat_cnt_d2", 64'(if2.cnt_d), 64'd3);
    chk("sat_cnt_d8", 64'(if8.cnt_d), 64'd6);

    // Asynchronous reset with a and c full
    if8.out_ready = 4'b0000;
    drive(32'hE0000001, 2'd0, 1'b1);
    cyc();
    drive(32'hE0000002, 2'd2, 1'b1);
    cyc();
    drive(32'h0, 2'd0, 1'b0);
    #1;
    chk("pre_rst_valid", 64'(if8.out_valid), 64'h5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid8", 64'(if8.out_valid), 64'h0);
    chk("arst_valid2", 64'(if2.out_valid), 64'h0);
    chk("arst_cnt_a", 64'(if8.cnt_a), 64'h0);
    chk("arst_cnt_b", 64'(if8.cnt_b), 64'h0);
    chk("arst_cnt_c", 64'(if8.cnt_c), 64'h0);
    chk("arst_cnt_d", 64'(if2.cnt_d), 64'h0);
    chk("arst_in_ready", 64'(if8.in_ready), 64'h1);
    cyc();
    rst_n = 1'b1;
    if8.out_ready = 4'b1111;
    repeat (3) cyc();
    chk("post_rst_cnt_a", 64'(if8.cnt_a), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
